// File: rtl/simulator.sv
// Top-level simulation sequencer: IDLE -> INIT (INIT_CYCLES edges) -> RUN (2^W edges) -> DONE.
// Publishes the registered phase and the run-phase cycle index.
module simulator #(
  parameter int MAX_CYCLE_WIDTH = 5,
  parameter int INIT_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic [1:0]                 state,
  output logic [MAX_CYCLE_WIDTH-1:0] current_cycle
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0]          INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [MAX_CYCLE_WIDTH-1:0] CYC_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INIT = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Power-up values match the reset values so benches see 00/0 before any reset.
  state_e                     state_q = IDLE;
  state_e                     state_d;
  logic [MAX_CYCLE_WIDTH-1:0] cycle_q = '0;
  logic [MAX_CYCLE_WIDTH-1:0] cycle_d;
  logic [INIT_W-1:0]          init_q  = '0;
  logic [INIT_W-1:0]          init_d;

  // reset_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      cycle_q <= '0;
      init_q  <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    init_d  = init_q;
    unique case (state_q)
      IDLE: begin
        state_d = INIT;
        init_d  = '0;
        cycle_d = '0;
      end
      INIT: begin
        cycle_d = '0;
        if (init_q == INIT_LAST) begin
          state_d = RUN;
          init_d  = '0;
        end else begin
          init_d  = init_q + 1'b1;
        end
      end
      RUN: begin
        // Saturate at all-ones: the last RUN value is also the DONE value.
        if (cycle_q == CYC_MAX) state_d = DONE;
        else                    cycle_d = cycle_q + 1'b1;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state         = state_q;
  assign current_cycle = cycle_q;

endmodule

// File: tb/tb_simulator.sv
// Bench for simulator: three parameterisations checked every edge against an
// edge-count model, plus lifecycle sequences, a vector table and random resets.
module tb_simulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r_a, r_b, r_c;
  logic [1:0] st_a, st_b, st_c;
  logic [4:0] cy_a;
  logic [7:0] cy_b;
  logic [0:0] cy_c;

  simulator #(.MAX_CYCLE_WIDTH(5), .INIT_CYCLES(2)) dut_a (
    .clk(clk), .reset_n(r_a), .state(st_a), .current_cycle(cy_a));
  simulator #(.MAX_CYCLE_WIDTH(8), .INIT_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(r_b), .state(st_b), .current_cycle(cy_b));
  simulator #(.MAX_CYCLE_WIDTH(1), .INIT_CYCLES(1)) dut_c (
    .clk(clk), .reset_n(r_c), .state(st_c), .current_cycle(cy_c));

  int errors = 0;
  int checks = 0;
  // Non-reset edges seen since the last reset edge, per instance.
  int n_a = 0, n_b = 0, n_c = 0;

  // Phase/cycle as a function of edges since reset, straight from the lifecycle rules.
  function automatic void model(input int n, input int w, input int ic,
                                output int st, output int cyc);
    int run_len;
    run_len = 1 << w;
    if (n == 0)                  begin st = 0; cyc = 0; end
    else if (n <= ic)            begin st = 1; cyc = 0; end
    else if (n <= ic + run_len)  begin st = 2; cyc = n - ic - 1; end
    else                         begin st = 3; cyc = run_len - 1; end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    int s, c;
    @(posedge clk);
    n_a = r_a ? 0 : (n_a < 100000 ? n_a + 1 : n_a);
    n_b = r_b ? 0 : (n_b < 100000 ? n_b + 1 : n_b);
    n_c = r_c ? 0 : (n_c < 100000 ? n_c + 1 : n_c);
    #1;
    model(n_a, 5, 2, s, c); chk("a.state", int'(st_a), s); chk("a.cycle", int'(cy_a), c);
    model(n_b, 8, 3, s, c); chk("b.state", int'(st_b), s); chk("b.cycle", int'(cy_b), c);
    model(n_c, 1, 1, s, c); chk("c.state", int'(st_c), s); chk("c.cycle", int'(cy_c), c);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] st;
    logic       cyc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    r_a = 1'b1; r_b = 1'b1; r_c = 1'b1;

    // Reset hold: three edges with reset asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.a.state", int'(st_a), 0);
      chk("hold.a.cycle", int'(cy_a), 0);
    end

    // Lifecycle W=5, INIT=2 (B and C run alongside under the per-edge model).
    r_a = 1'b0; r_b = 1'b0; r_c = 1'b0;
    tick();   chk("life.e1.state", int'(st_a), 1);
    ticks(2); chk("life.e3.state", int'(st_a), 2); chk("life.e3.cycle", int'(cy_a), 0);
    ticks(31); chk("life.e34.state", int'(st_a), 2); chk("life.e34.cycle", int'(cy_a), 31);
    tick();   chk("life.e35.state", int'(st_a), 3); chk("life.e35.cycle", int'(cy_a), 31);

    // DONE hold.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("done_hold.state", int'(st_a), 3);
      chk("done_hold.cycle", int'(cy_a), 31);
    end

    // Reset in DONE, then reset mid-RUN at cycle 12.
    r_a = 1'b1; tick();
    chk("rst_done.state", int'(st_a), 0); chk("rst_done.cycle", int'(cy_a), 0);
    r_a = 1'b0; ticks(15);
    chk("pre_mid.state", int'(st_a), 2); chk("pre_mid.cycle", int'(cy_a), 12);
    r_a = 1'b1; tick();
    chk("rst_run.state", int'(st_a), 0); chk("rst_run.cycle", int'(cy_a), 0);
    r_a = 1'b0; ticks(34);
    chk("restart.e34.cycle", int'(cy_a), 31); chk("restart.e34.state", int'(st_a), 2);
    tick(); chk("restart.e35.state", int'(st_a), 3);

    // Reset mid-INIT.
    r_a = 1'b1; tick(); r_a = 1'b0; ticks(2);
    chk("mid_init.state", int'(st_a), 1);
    r_a = 1'b1; tick();
    chk("rst_init.state", int'(st_a), 0); chk("rst_init.cycle", int'(cy_a), 0);
    r_a = 1'b0; ticks(35);
    chk("after_init_rst.state", int'(st_a), 3); chk("after_init_rst.cycle", int'(cy_a), 31);

    // W=8, INIT=3: reaches 255 then DONE, never wraps.
    r_b = 1'b1; tick(); r_b = 1'b0;
    ticks(259);
    chk("w8.e259.state", int'(st_b), 2); chk("w8.e259.cycle", int'(cy_b), 255);
    tick();
    chk("w8.e260.state", int'(st_b), 3); chk("w8.e260.cycle", int'(cy_b), 255);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("w8.hold.cycle", int'(cy_b), 255);
    end

    // W=1, INIT=1 vector table.
    vecs[0] = '{1'b1, 2'b00, 1'b0};
    vecs[1] = '{1'b0, 2'b01, 1'b0};
    vecs[2] = '{1'b0, 2'b10, 1'b0};
    vecs[3] = '{1'b0, 2'b10, 1'b1};
    vecs[4] = '{1'b0, 2'b11, 1'b1};
    vecs[5] = '{1'b0, 2'b11, 1'b1};
    vecs[6] = '{1'b1, 2'b00, 1'b0};
    vecs[7] = '{1'b0, 2'b01, 1'b0};
    vecs[8] = '{1'b1, 2'b00, 1'b0};
    vecs[9] = '{1'b0, 2'b01, 1'b0};
    foreach (vecs[i]) begin
      r_c = vecs[i].rst;
      tick();
      chk($sformatf("vec%0d.state", i), int'(st_c), int'(vecs[i].st));
      chk($sformatf("vec%0d.cycle", i), int'(cy_c), int'(vecs[i].cyc));
    end

    // Random reset pulses on all instances, checked each edge by the model.
    for (int i = 0; i < 3000; i++) begin
      r_a = ($urandom_range(0, 59) == 0);
      r_b = ($urandom_range(0, 299) == 0);
      r_c = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
